// File: rtl/addsub_sat_seq_if.sv
// Request/response bundle for the chunked add/subtract unit.
// The master side issues operands and consumes results; the slave side is the unit itself.
interface addsub_sat_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ovfl;
    logic             neg;
    logic             zero;

    modport master (
        output in_valid, A, B, sub, sat_en, out_ready,
        input  in_ready, out_valid, result, ovfl, neg, zero
    );

    modport slave (
        input  in_valid, A, B, sub, sat_en, out_ready,
        output in_ready, out_valid, result, ovfl, neg, zero
    );
endinterface

// File: rtl/addsub_sat_seq.sv
// Multi-cycle signed add/subtract with optional saturation. The operands are
// summed CHUNK bits per cycle through a narrow carry chain; flags describe the delivered result.
//
//   state  | meaning
//   IDLE   | ready for a new request (in_ready=1)
//   CALC   | one chunk of the latched operands summed per cycle
//   DONE   | result and flags presented until out_ready
module addsub_sat_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    addsub_sat_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;

    localparam logic [CW-1:0]    LAST    = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("addsub_sat_seq: WIDTH must be at least 2");
        end
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("addsub_sat_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             carry_q,  carry_d;
    logic             sat_q,    sat_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] psum_q,   psum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovfl_q,   ovfl_d;
    logic             neg_q,    neg_d;
    logic             zero_q,   zero_d;

    int               lo;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] raw;
    logic             v;
    logic [WIDTH-1:0] final_res;

    // Datapath for the chunk currently addressed by the counter; raw is the
    // partial sum with this cycle's chunk merged in, complete on the last chunk.
    always_comb begin
        lo        = int'(cnt_q) * CHUNK;
        chunk_sum = {1'b0, a_q[lo +: CHUNK]} + {1'b0, b_q[lo +: CHUNK]} + {{CHUNK{1'b0}}, carry_q};
        raw       = psum_q;
        raw[lo +: CHUNK] = chunk_sum[CHUNK-1:0];
        v         = (a_q[MSB] == b_q[MSB]) && (raw[MSB] != a_q[MSB]);
        final_res = (v && sat_q) ? (a_q[MSB] ? MIN_NEG : MAX_POS) : raw;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        sat_d    = sat_q;
        cnt_d    = cnt_q;
        psum_d   = psum_q;
        result_d = result_q;
        ovfl_d   = ovfl_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.sub ? ~bus.B : bus.B;
                    carry_d = bus.sub;
                    sat_d   = bus.sat_en;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                psum_d  = raw;
                carry_d = chunk_sum[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    result_d = final_res;
                    ovfl_d   = v;
                    neg_d    = final_res[MSB];
                    zero_d   = (final_res == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            sat_q    <= 1'b0;
            cnt_q    <= '0;
            psum_q   <= '0;
            result_q <= '0;
            ovfl_q   <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
            psum_q   <= psum_d;
            result_q <= result_d;
            ovfl_q   <= ovfl_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.ovfl      = ovfl_q;
    assign bus.neg       = neg_q;
    assign bus.zero      = zero_q;
endmodule
